// File: rtl/pwm_audio_pkg.sv
// Shared types and constants for the PWM audio sample path (FIFO and modulator).
package pwm_audio_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_AF_THRESH  = 48;
    localparam int DEF_AE_THRESH  = 16;

    typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

    // Address width for a power-of-two FIFO depth; pointers carry one extra wrap bit.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pwm_fifo_ctrl.sv
// FIFO control: read/write pointers with wrap bit, fill level, full/empty and
// watermark flags, sticky overflow/underflow and synchronous flush.
module pwm_fifo_ctrl
    import pwm_audio_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       w_en_i,
    input  logic                       r_en_i,
    input  logic                       err_clr_i,
    output logic                       wr_acc_o,
    output logic                       rd_acc_o,
    output logic [addr_w(DEPTH)-1:0]   waddr_o,
    output logic [addr_w(DEPTH)-1:0]   raddr_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [addr_w(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int AW = addr_w(DEPTH);
    localparam logic [AW:0] AF_L = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_L = AE_THRESH[AW:0];
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] level_q, level_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    // Flags come only from registered state, so they reflect the pre-edge FIFO.
    assign full_o         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o        = (wptr_q == rptr_q);
    assign almost_full_o  = (level_q >= AF_L);
    assign almost_empty_o = (level_q <= AE_L);
    assign level_o        = level_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
    assign waddr_o        = wptr_q[AW-1:0];
    assign raddr_o        = rptr_q[AW-1:0];

    // Flush swallows both requests in its cycle.
    assign wr_acc_o = w_en_i & ~full_o  & ~flush_i;
    assign rd_acc_o = r_en_i & ~empty_o & ~flush_i;

    // Next-state: pointer advance, level tracking, sticky error flags (set beats clear).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (err_clr_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (w_en_i && full_o)  ovf_d = 1'b1;
        if (r_en_i && empty_o) unf_d = 1'b1;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_acc_o) wptr_d = wptr_q + ONE;
            if (rd_acc_o) rptr_d = rptr_q + ONE;
            case ({wr_acc_o, rd_acc_o})
                2'b10:   level_d = level_q + ONE;
                2'b01:   level_d = level_q - ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: rtl/pwm_audio_fifo.sv
// Sample FIFO between the audio producer and the PWM modulator.
// Holds the storage array and the read data path; control lives in pwm_fifo_ctrl.
// Build option: define PWM_FIFO_FWFT_EN for first-word fall-through reads
// (head word shown combinationally, data_valid = !empty). Default is a
// registered read with one cycle of latency and a one-cycle data_valid pulse.
module pwm_audio_fifo
    import pwm_audio_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AF_THRESH  = DEF_AF_THRESH,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     w_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     r_en,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int AW = addr_w(DEPTH);

    logic                  wr_acc, rd_acc;
    logic [AW-1:0]         waddr, raddr;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    pwm_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    ) u_ctrl (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .w_en_i         (w_en),
        .r_en_i         (r_en),
        .err_clr_i      (err_clr),
        .wr_acc_o       (wr_acc),
        .rd_acc_o       (rd_acc),
        .waddr_o        (waddr),
        .raddr_o        (raddr),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .level_o        (level),
        .overflow_o     (overflow),
        .underflow_o    (underflow)
    );

    // Sample storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[waddr] <= data_in;
    end

`ifdef PWM_FIFO_FWFT_EN
    logic unused_rd_acc;
    assign unused_rd_acc = rd_acc;

    // Head word falls through; r_en only acknowledges it.
    assign data_out   = mem_q[raddr];
    assign data_valid = ~empty;
`else
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dval_q;

    // Registered pop: data_out loads on an accepted read and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            dval_q <= 1'b0;
        end else if (flush) begin
            dout_q <= '0;
            dval_q <= 1'b0;
        end else begin
            dval_q <= rd_acc;
            if (rd_acc) dout_q <= mem_q[raddr];
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dval_q;
`endif

endmodule

// File: tb/tb_pwm_audio_fifo.sv
// Self-checking bench for pwm_audio_fifo: directed scenarios plus randomized
// traffic, all checked every cycle against a queue-based model.
module tb_pwm_audio_fifo;

    localparam int DEPTH = 64;
    localparam int DW    = 8;
    localparam int AF    = 48;
    localparam int AE    = 16;

    logic          clk = 1'b0;
    logic          rst, flush, w_en, r_en, err_clr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_valid, full, empty, almost_full, almost_empty;
    logic [6:0]    level;
    logic          overflow, underflow;

    pwm_audio_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in),
        .r_en(r_en), .data_out(data_out), .data_valid(data_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: a queue of stored samples plus the visible output state.
    logic [DW-1:0] mq[$];
    logic          m_ovf, m_unf, m_dval;
    logic [DW-1:0] m_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dval = 1'b0;
        m_dout = '0;
    endtask

    task automatic model_step(input logic w, input logic [DW-1:0] d, input logic r,
                              input logic f, input logic ec);
        bit was_full, was_empty;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_ovf = (w && was_full)  ? 1'b1 : (ec ? 1'b0 : m_ovf);
        m_unf = (r && was_empty) ? 1'b1 : (ec ? 1'b0 : m_unf);
        if (f) begin
            mq.delete();
            m_dout = '0;
            m_dval = 1'b0;
        end else begin
            m_dval = 1'b0;
            if (r && !was_empty) begin
                m_dout = mq.pop_front();
                m_dval = 1'b1;
            end
            if (w && !was_full) mq.push_back(d);
        end
    endtask

    task automatic check_all();
        chk("level", 32'(level), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef PWM_FIFO_FWFT_EN
        chk("data_valid", 32'(data_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("data_out", 32'(data_out), 32'(mq[0]));
`else
        chk("data_valid", 32'(data_valid), 32'(m_dval));
        chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic f, input logic ec);
        w_en = w; data_in = d; r_en = r; flush = f; err_clr = ec;
        @(posedge clk);
        model_step(w, d, r, f, ec);
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        check_all();
    endtask

    task automatic check_reset_literals(input string tag);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_ae"}, 32'(almost_empty), 1);
        chk({tag, "_af"}, 32'(almost_full), 0);
        chk({tag, "_dv"}, 32'(data_valid), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_unf"}, 32'(underflow), 0);
`ifndef PWM_FIFO_FWFT_EN
        chk({tag, "_dout"}, 32'(data_out), 0);
`endif
    endtask

    initial begin
        int wp[6];
        int rp[6];
        logic [DW-1:0] rd8;
        wp = '{20, 80, 50, 95, 5, 60};
        rp = '{80, 20, 50, 5, 95, 60};

        rst = 1'b1; flush = 0; w_en = 0; r_en = 0; err_clr = 0; data_in = '0;
        model_reset();
        @(negedge clk);
        check_reset_literals("reset");
        rst = 1'b0;

        // 1: fill to full, watermark at 48, 65th write dropped
        for (int i = 1; i <= 64; i++) begin
            cyc(1, DW'(i), 0, 0, 0);
            if (i == 47) chk("t1_af_at47", 32'(almost_full), 0);
            if (i == 48) chk("t1_af_at48", 32'(almost_full), 1);
        end
        chk("t1_level64", 32'(level), 64);
        chk("t1_full", 32'(full), 1);
        cyc(1, 8'hAA, 0, 0, 0);
        chk("t1_overflow", 32'(overflow), 1);
        chk("t1_level_hold", 32'(level), 64);

        // 2: drain in order, then underflow and error clear
        for (int i = 1; i <= 64; i++) begin
`ifdef PWM_FIFO_FWFT_EN
            chk("t2_head", 32'(data_out), 32'(i));
`endif
            cyc(0, '0, 1, 0, 0);
`ifndef PWM_FIFO_FWFT_EN
            chk("t2_data", 32'(data_out), 32'(i));
`endif
        end
        chk("t2_empty", 32'(empty), 1);
        cyc(0, '0, 1, 0, 0);
        chk("t2_underflow", 32'(underflow), 1);
        cyc(0, '0, 0, 0, 1);
        chk("t2_clr_ovf", 32'(overflow), 0);
        chk("t2_clr_unf", 32'(underflow), 0);

        // 3: steady level 10 with simultaneous traffic, pointers wrap several times
        for (int i = 0; i < 10; i++) cyc(1, DW'($urandom), 0, 0, 0);
        for (int i = 0; i < 200; i++) cyc(1, DW'($urandom), 1, 0, 0);
        chk("t3_level10", 32'(level), 10);

        // 4: read+write at full and at empty
        for (int i = 0; i < 54; i++) cyc(1, DW'($urandom), 0, 0, 0);
        cyc(1, 8'h55, 1, 0, 0);
        chk("t4_full_level63", 32'(level), 63);
        chk("t4_full_ovf", 32'(overflow), 1);
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 63; i++) cyc(0, '0, 1, 0, 0);
        cyc(1, 8'h66, 1, 0, 0);
        chk("t4_empty_level1", 32'(level), 1);
        chk("t4_empty_unf", 32'(underflow), 1);

        // 5: flush at level 20 with a concurrent write
        for (int i = 0; i < 19; i++) cyc(1, DW'($urandom), 0, 0, 0);
        chk("t5_level20", 32'(level), 20);
        cyc(1, 8'h77, 0, 1, 0);
        chk("t5_level0", 32'(level), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_dv", 32'(data_valid), 0);
        chk("t5_unf_kept", 32'(underflow), 1);

        // 6: asynchronous reset between edges
        for (int i = 0; i < 5; i++) cyc(1, DW'(i + 3), i[0], 0, 0);
        cyc(0, '0, 1, 0, 0);
        #2 rst = 1'b1;
        #1 check_reset_literals("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 8'h9C, 0, 0, 0);
`ifdef PWM_FIFO_FWFT_EN
        chk("t6_fwft_dv", 32'(data_valid), 1);
        chk("t6_fwft_dout", 32'(data_out), 32'h9C);
`else
        chk("t6_std_dv", 32'(data_valid), 0);
`endif

        // Randomized traffic in phases biased toward filling, draining and churning
        for (int ph = 0; ph < 6; ph++) begin
            for (int n = 0; n < 500; n++) begin
                rd8 = DW'($urandom);
                cyc($urandom_range(99) < wp[ph], rd8, $urandom_range(99) < rp[ph],
                    $urandom_range(99) < 2, $urandom_range(99) < 3);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
